// File: rtl/axi_sram_slave_p_if.sv
// axi_sram_slave_p_if
//   AXI4 bus bundle (AR, R, AW, W, B channels) between a master and the
//   axi_sram_slave_p memory slave. Clock and reset are kept outside the bundle.
//   Modports:
//     master : drives AR/AW/W payload + VALID, RREADY, BREADY
//     slave  : drives ARREADY, AWREADY, WREADY, R payload + VALID, B payload + VALID
interface axi_sram_slave_p_if #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  // Read address channel
  logic [ID_WIDTH-1:0]   ARID_S;
  logic [31:0]           ARADDR_S;
  logic [3:0]            ARLEN_S;
  logic [2:0]            ARSIZE_S;
  logic [1:0]            ARBURST_S;
  logic                  ARVALID_S;
  logic                  ARREADY_S;
  // Read data channel
  logic [ID_WIDTH-1:0]   RID_S;
  logic [DATA_WIDTH-1:0] RDATA_S;
  logic [1:0]            RRESP_S;
  logic                  RLAST_S;
  logic                  RVALID_S;
  logic                  RREADY_S;
  // Write address channel
  logic [ID_WIDTH-1:0]   AWID_S;
  logic [31:0]           AWADDR_S;
  logic [3:0]            AWLEN_S;
  logic [2:0]            AWSIZE_S;
  logic [1:0]            AWBURST_S;
  logic                  AWVALID_S;
  logic                  AWREADY_S;
  // Write data channel
  logic [DATA_WIDTH-1:0] WDATA_S;
  logic [STRB-1:0]       WSTRB_S;
  logic                  WLAST_S;
  logic                  WVALID_S;
  logic                  WREADY_S;
  // Write response channel
  logic [ID_WIDTH-1:0]   BID_S;
  logic [1:0]            BRESP_S;
  logic                  BVALID_S;
  logic                  BREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S
  );
endinterface

// File: rtl/axi_sram_slave_p.sv
// axi_sram_slave_p
//   AXI4 slave fronting a synchronous single-port SRAM of DEPTH words.
//   Handles one burst at a time (FIXED/INCR/WRAP), arbitrates simultaneous
//   AR/AW round-robin, answers SLVERR for illegal bursts and out-of-range beats.
//   Ports:
//     ACLK    : clock
//     ARESETn : asynchronous active-low reset (array contents are kept)
//     s       : AXI4 bus bundle, slave side
module axi_sram_slave_p #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384
) (
  input logic               ACLK,
  input logic               ARESETn,
  axi_sram_slave_p_if.slave s
);
  localparam int          STRB        = DATA_WIDTH / 8;
  localparam int          LSB         = $clog2(STRB);
  localparam int          IDX_W       = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE    = 3'(LSB);
  localparam logic [32:0] BYTE_LIMIT  = 33'(DEPTH) * 33'(STRB);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_R_FETCH = 3'd1,
    S_R_DATA  = 3'd2,
    S_W_DATA  = 3'd3,
    S_W_RESP  = 3'd4
  } state_t;

  // Whole-burst legality: oversize beats, reserved burst type, bad WRAP length.
  function automatic logic f_burst_err(input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size > MAX_SIZE) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // Address of the following beat; WRAP stays inside a (LEN+1)*2^size container.
  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, aligned, incr, wmask, result;
    step    = 32'd1 << size;
    aligned = addr & ~(step - 32'd1);
    incr    = aligned + step;
    wmask   = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: result = addr;
      BURST_INCR:  result = incr;
      BURST_WRAP:  result = (aligned & ~wmask) | (incr & wmask);
      default:     result = addr;
    endcase
    return result;
  endfunction

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [31:0]           r_addr;
  logic [3:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_burst_err, r_werr, r_prefer_w;
  logic [ID_WIDTH-1:0]   r_rid, r_bid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp, r_bresp;
  logic                  r_rlast;
  logic                  w_aw_grant, w_ar_grant, w_err, w_wr_en;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_next_addr;

  // Only the granted channel sees READY; ties go to the class not served last.
  assign w_aw_grant  = (r_state == S_IDLE) && s.AWVALID_S && (!s.ARVALID_S || r_prefer_w);
  assign w_ar_grant  = (r_state == S_IDLE) && s.ARVALID_S && (!s.AWVALID_S || !r_prefer_w);
  assign w_err       = r_burst_err || ({1'b0, r_addr} >= BYTE_LIMIT);
  assign w_idx       = r_addr[LSB +: IDX_W];
  assign w_next_addr = f_next_addr(r_addr, r_len, r_size, r_burst);
  assign w_wr_en     = (r_state == S_W_DATA) && s.WVALID_S && !w_err;

  assign s.ARREADY_S = w_ar_grant;
  assign s.AWREADY_S = w_aw_grant;
  assign s.WREADY_S  = (r_state == S_W_DATA);
  assign s.RVALID_S  = (r_state == S_R_DATA);
  assign s.BVALID_S  = (r_state == S_W_RESP);
  assign s.RDATA_S   = r_rdata;
  assign s.RRESP_S   = r_rresp;
  assign s.RLAST_S   = r_rlast;
  assign s.RID_S     = r_rid;
  assign s.BID_S     = r_bid;
  assign s.BRESP_S   = r_bresp;

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_grant) begin
          w_next = S_W_DATA;
        end else if (w_ar_grant) begin
          w_next = S_R_FETCH;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_R_FETCH: w_next = S_R_DATA;
      S_R_DATA: begin
        if (s.RREADY_S) begin
          w_next = r_rlast ? S_IDLE : S_R_FETCH;
        end else begin
          w_next = S_R_DATA;
        end
      end
      S_W_DATA: begin
        // WLAST ends the burst regardless of the beat counter
        if (s.WVALID_S && s.WLAST_S) begin
          w_next = S_W_RESP;
        end else begin
          w_next = S_W_DATA;
        end
      end
      S_W_RESP: begin
        if (s.BREADY_S) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_W_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Burst context capture, per-beat address stepping and response registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr      <= 32'd0;
      r_len       <= 4'd0;
      r_cnt       <= 4'd0;
      r_size      <= 3'd0;
      r_burst     <= 2'd0;
      r_burst_err <= 1'b0;
      r_werr      <= 1'b0;
      r_prefer_w  <= 1'b1;
      r_rid       <= '0;
      r_bid       <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_bresp     <= RESP_OKAY;
      r_rlast     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_grant) begin
            r_addr      <= s.AWADDR_S;
            r_len       <= s.AWLEN_S;
            r_size      <= s.AWSIZE_S;
            r_burst     <= s.AWBURST_S;
            r_burst_err <= f_burst_err(s.AWLEN_S, s.AWSIZE_S, s.AWBURST_S);
            r_bid       <= s.AWID_S;
            r_cnt       <= 4'd0;
            r_werr      <= 1'b0;
            r_prefer_w  <= 1'b0;
          end else if (w_ar_grant) begin
            r_addr      <= s.ARADDR_S;
            r_len       <= s.ARLEN_S;
            r_size      <= s.ARSIZE_S;
            r_burst     <= s.ARBURST_S;
            r_burst_err <= f_burst_err(s.ARLEN_S, s.ARSIZE_S, s.ARBURST_S);
            r_rid       <= s.ARID_S;
            r_cnt       <= 4'd0;
            r_prefer_w  <= 1'b1;
          end
        end
        S_R_FETCH: begin
          // Synchronous array read lands straight in the output register
          r_rdata <= w_err ? '0 : r_mem[w_idx];
          r_rresp <= w_err ? RESP_SLVERR : RESP_OKAY;
          r_rlast <= (r_cnt == r_len);
        end
        S_R_DATA: begin
          if (s.RREADY_S) begin
            r_addr  <= w_next_addr;
            r_cnt   <= r_cnt + 4'd1;
            r_rlast <= 1'b0;
          end
        end
        S_W_DATA: begin
          if (s.WVALID_S) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 4'd1;
            r_werr <= r_werr || w_err;
            if (s.WLAST_S) begin
              r_bresp <= (r_werr || w_err) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte-masked array write; contents deliberately survive reset
  always_ff @(posedge ACLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < STRB; b++) begin
        if (s.WSTRB_S[b]) begin
          r_mem[w_idx][b*8 +: 8] <= s.WDATA_S[b*8 +: 8];
        end
      end
    end
  end
endmodule
